// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, PAYLOAD_BITS data bits LSB first, no parity, one checked stop bit.
// Samples each bit at its midpoint and reports good words, breaks and framing errors as 1-cycle strobes.
module uart_rx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_break,
    output logic                    uart_rx_ferr
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAYLOAD_BITS - 1);

    // Stop bits beyond the first are simply waited out in IDLE.
    if (STOP_BITS < 1 || CYCLES_PER_BIT < 2 || PAYLOAD_BITS < 2) begin : g_bad_params
        $error("uart_rx: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next;
    logic [1:0]              sync_r;
    logic                    rxd_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [PAYLOAD_BITS-1:0] shift_r;
    logic                    armed_r;
    logic                    data_tick_s;
    logic                    valid_set_s;
    logic                    break_set_s;
    logic                    ferr_set_s;

    assign rxd_s       = sync_r[1];
    assign data_tick_s = (state_r == DATA) && (cnt_r == CNT_LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], uart_rxd};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next state and strobe requests; disabling the receiver overrides everything.
    always_comb begin
        state_next  = state_r;
        valid_set_s = 1'b0;
        break_set_s = 1'b0;
        ferr_set_s  = 1'b0;
        if (!uart_rx_en) begin
            state_next = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (armed_r && !rxd_s) begin
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
                START: begin
                    if (cnt_r == CNT_HALF) begin
                        state_next = rxd_s ? IDLE : DATA;
                    end else begin
                        state_next = START;
                    end
                end
                DATA: begin
                    if (data_tick_s && (bit_cnt_r == BIT_LAST)) begin
                        state_next = STOP;
                    end else begin
                        state_next = DATA;
                    end
                end
                STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        state_next = IDLE;
                        if (rxd_s) begin
                            valid_set_s = 1'b1;
                        end else if (shift_r == {PAYLOAD_BITS{1'b0}}) begin
                            break_set_s = 1'b1;
                        end else begin
                            ferr_set_s = 1'b1;
                        end
                    end else begin
                        state_next = STOP;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Bit-period counter, restarted on every state entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_next != state_r) || (state_r == IDLE) || (cnt_r == CNT_LAST)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Data bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {PAYLOAD_BITS{1'b0}};
        end else begin
            if (state_r != DATA) begin
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (data_tick_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (data_tick_s) begin
                shift_r <= {rxd_s, shift_r[PAYLOAD_BITS-1:1]};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Arming: a low line left over from a break must go high before a new start is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed_r <= 1'b0;
        end else if ((state_r == STOP) && (state_next != STOP)) begin
            armed_r <= 1'b0;
        end else if ((state_r == IDLE) && rxd_s) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Registered strobes; the data word only moves on a good frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_ferr  <= 1'b0;
            uart_rx_data  <= {PAYLOAD_BITS{1'b0}};
        end else begin
            uart_rx_valid <= valid_set_s;
            uart_rx_break <= break_set_s;
            uart_rx_ferr  <= ferr_set_s;
            if (valid_set_s) begin
                uart_rx_data <= shift_r;
            end else begin
                uart_rx_data <= uart_rx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with a short bit period (131 clocks per bit, odd on purpose).
module tb_uart_rx;

    localparam int BIT_RATE   = 9600;
    localparam int CLK_HZ     = 1257600;
    localparam int CPB        = CLK_HZ / BIT_RATE;
    localparam int HALF       = CPB / 2;
    // Edges from driving the start bit to the strobe: 2 synchroniser + 1 IDLE decision + midpoint + 9 bits.
    localparam int STROBE_LAT = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic       brk;
    logic       ferr;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         n_valid = 0;
    int         n_break = 0;
    int         n_ferr = 0;
    int         last_valid_cyc = 0;
    int         bv, bb, bf, t0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_b[20];

    uart_rx #(
        .BIT_RATE(BIT_RATE),
        .CLK_HZ(CLK_HZ),
        .PAYLOAD_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .uart_rxd(rxd),
        .uart_rx_en(en),
        .uart_rx_valid(valid),
        .uart_rx_data(data),
        .uart_rx_break(brk),
        .uart_rx_ferr(ferr)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            rx_q.push_back(data);
        end
        if (brk) n_break++;
        if (ferr) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        bv = n_valid;
        bb = n_break;
        bf = n_ferr;
    endtask

    initial begin
        resetn = 1'b0;
        rxd    = 1'b1;
        en     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_break", 32'(brk), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        resetn = 1'b1;
        idle(10);

        // 1: single frame, exact strobe latency
        snap();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("t1_count", 32'(n_valid - bv), 32'd1);
        check("t1_data", 32'(data), 32'hA5);
        check("t1_latency", 32'(last_valid_cyc - t0), 32'(STROBE_LAT));
        check("t1_errs", 32'(n_break + n_ferr - bb - bf), 32'd0);

        // 2: 20 back-to-back frames
        rx_q.delete();
        snap();
        for (int i = 0; i < 20; i++) begin
            exp_b[i] = 8'($random);
            send_frame(exp_b[i], 1'b1);
        end
        idle(CPB);
        check("t2_count", 32'(n_valid - bv), 32'd20);
        check("t2_errs", 32'(n_break + n_ferr - bb - bf), 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("t2_data", (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_b[i]});
        end

        // 3: 1000 ns low glitch on an idle line
        snap();
        rxd = 1'b0;
        #1000;
        rxd = 1'b1;
        idle(3 * CPB);
        check("t3_valid", 32'(n_valid - bv), 32'd0);
        check("t3_errs", 32'(n_break + n_ferr - bb - bf), 32'd0);
        check("t3_data", 32'(data), {24'h0, exp_b[19]});

        // 4: framing error, break, then recovery
        snap();
        send_frame(8'h3C, 1'b0);
        idle(CPB);
        check("t4_ferr", 32'(n_ferr - bf), 32'd1);
        check("t4_ferr_other", 32'(n_valid + n_break - bv - bb), 32'd0);
        check("t4_ferr_data", 32'(data), {24'h0, exp_b[19]});
        snap();
        rxd = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        idle(2 * CPB);
        check("t4_break", 32'(n_break - bb), 32'd1);
        check("t4_break_other", 32'(n_valid + n_ferr - bv - bf), 32'd0);
        check("t4_break_data", 32'(data), {24'h0, exp_b[19]});
        snap();
        send_frame(8'h81, 1'b1);
        idle(CPB);
        check("t4_rec_count", 32'(n_valid - bv), 32'd1);
        check("t4_rec_data", 32'(data), 32'h81);

        // 5: disable after bit 3 of 0xFF, then re-enable
        snap();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        idle(CPB);
        en = 1'b1;
        idle(CPB);
        check("t5_no_strobe", 32'(n_valid + n_break + n_ferr - bv - bb - bf), 32'd0);
        check("t5_data_kept", 32'(data), 32'h81);
        send_frame(8'h12, 1'b1);
        idle(CPB);
        check("t5_count", 32'(n_valid - bv), 32'd1);
        check("t5_data", 32'(data), 32'h12);

        // 6: reset mid-frame, then 0x55
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        resetn = 1'b0;
        rxd    = 1'b1;
        #1;
        check("t6_rst_data", 32'(data), 32'd0);
        check("t6_rst_strobes", {29'h0, valid, brk, ferr}, 32'd0);
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        snap();
        idle(2 * CPB);
        send_frame(8'h55, 1'b1);
        idle(CPB);
        check("t6_count", 32'(n_valid - bv), 32'd1);
        check("t6_data", 32'(data), 32'h55);
        check("t6_errs", 32'(n_break + n_ferr - bb - bf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive-side counterpart to uart_tx, sharing the same line format of 1 start bit, PAYLOAD_BITS data bits LSB first, and STOP_BITS stop bits, with no parity. Oversamples the asynchronous uart_rxd pin with the system clock and samples each bit at its midpoint. Presents each received word as a one-cycle valid strobe, and separately flags break and framing errors. Sits between the board RX pin and any byte consumer.

Parameters:
BIT_RATE, 9600, line bit rate in bits/s
CLK_HZ, 50000000, clk frequency in Hz
PAYLOAD_BITS, 8, data bits per frame
STOP_BITS, 1, stop bits expected; only the first is checked
Derived, not overridable: CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide); HALF_BIT = CYCLES_PER_BIT/2

Ports:
clk  input  1  system clock; all logic on the rising edge
resetn  input  1  asynchronous, active-low reset
uart_rxd  input  1  asynchronous UART receive pin; idles high
uart_rx_en  input  1  receive enable
uart_rx_valid  output  1  one-cycle strobe: uart_rx_data holds a new good word
uart_rx_data  output  PAYLOAD_BITS  last good received word
uart_rx_break  output  1  one-cycle strobe: break detected (all-zero data and stop bit 0)
uart_rx_ferr  output  1  one-cycle strobe: framing error (stop bit 0, data not all zero)

Behaviour:
- Reset values: uart_rx_valid=0, uart_rx_break=0, uart_rx_ferr=0, uart_rx_data=0; FSM=IDLE; synchroniser flops=1; counters=0.
- uart_rxd passes through a 2-flop synchroniser to produce rxd_s. All decisions use rxd_s only. This adds 2 cycles of latency.
- Cycle counter: counts 0..CYCLES_PER_BIT-1. It is cleared on every state entry.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: the block is armed only after rxd_s has been 1 for at least one cycle since leaving STOP or since reset. While armed, rxd_s==0 with uart_rx_en==1 moves to START. Call this cycle T0.
- START: at count==HALF_BIT-1, sample rxd_s. If 1, treat as a glitch: return to IDLE with no strobe. If 0, go to DATA.
- DATA: sample rxd_s at count==CYCLES_PER_BIT-1 and shift it in LSB first. After PAYLOAD_BITS samples, go to STOP.
- STOP: sample at count==CYCLES_PER_BIT-1, then return to IDLE in the same cycle.
  - Sample 1: load uart_rx_data from the shift register and pulse uart_rx_valid in the next cycle.
  - Sample 0 with shift register all zeros: pulse uart_rx_break; uart_rx_data is unchanged.
  - Sample 0 otherwise: pulse uart_rx_ferr; uart_rx_data is unchanged.
- Strobes are mutually exclusive and last exactly 1 cycle.
- Sample instants, relative to T0:
  - start check: T0+HALF_BIT
  - data bit k: T0+HALF_BIT+(k+1)*CYCLES_PER_BIT
  - stop: T0+HALF_BIT+(PAYLOAD_BITS+1)*CYCLES_PER_BIT
  - strobe: one cycle after the stop sample.
- Back-to-back frames: the remaining stop time after midpoint is waited out in IDLE, so the next start edge is accepted without loss. Extra STOP_BITS are not checked.
- After a break, no new frame starts until the line returns high (arming rule).
- uart_rx_en low in any state: return to IDLE at the next edge, discard the partial word, emit no strobe. uart_rx_data keeps its value.
- uart_rx_data changes only on a good frame and is stable between strobes.
- resetn asserted mid-frame: everything returns to reset values immediately. No strobe is generated after release.

Test Plan:
1. Defaults (CYCLES_PER_BIT=5208). Drive frame 0xA5 at 9600 b/s with stop=1 -> exactly one uart_rx_valid pulse, uart_rx_data=0xA5, strobe at T0+2604+9*5208+1 cycles.
2. 20 back-to-back $random bytes, one stop bit, no idle gap -> 20 valid pulses; data matches in order; no break/ferr.
3. Low glitch of 1000 ns on idle line -> START aborts; no strobe; FSM back in IDLE.
4. Frame 0x3C with stop bit 0 -> uart_rx_ferr one cycle; uart_rx_data keeps previous value. Line held low for 12 bit times -> one uart_rx_break pulse only; next frame 0x81 after line high -> valid with data 0x81.
5. Drop uart_rx_en after bit 3 of frame 0xFF -> no strobe. Re-enable and send 0x12 -> valid with 0x12.
6. Assert resetn low mid-frame for 100 ns, then send 0x55 -> outputs 0 during reset; only one valid pulse, with 0x55.
